// File: rtl/icache_dm_if.sv
// Slowmem read bus between the instruction cache (master) and slowmem (slave).
interface icache_dm_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_strobe;
  logic              mem_rnotw;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_mfc;

  modport master (
    output mem_addr,
    output mem_strobe,
    output mem_rnotw,
    input  mem_rdata,
    input  mem_mfc
  );

  modport slave (
    input  mem_addr,
    input  mem_strobe,
    input  mem_rnotw,
    output mem_rdata,
    output mem_mfc
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: zero-latency hit path, single-word fills
// over the slowmem strobe/mfc handshake, store snooping, single-cycle flush and a
// saturating miss counter.
module icache_dm #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned INDEX_W = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  // Fetch side
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] instr,
  output logic              hit,
  output logic              busy,
  // Maintenance
  input  logic              flush,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic [DATA_W-1:0] snoop_data,
  // Slowmem
  icache_dm_if.master       mem,
  // Performance
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              strobe_q, strobe_d;
  logic              drop_q, drop_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  logic [INDEX_W-1:0] req_idx, fill_idx, snoop_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag, snoop_tag;
  logic               install;
  logic               snoop_hit;
  logic               snoop_to_fill;
  logic               snoop_upd;

  assign req_idx   = req_addr[INDEX_W-1:0];
  assign req_tag   = req_addr[ADDR_W-1:INDEX_W];
  assign fill_idx  = fill_addr_q[INDEX_W-1:0];
  assign fill_tag  = fill_addr_q[ADDR_W-1:INDEX_W];
  assign snoop_idx = snoop_addr[INDEX_W-1:0];
  assign snoop_tag = snoop_addr[ADDR_W-1:INDEX_W];

  // Hit path is purely combinational from the request and the arrays.
  assign hit   = req_valid & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign instr = data_q[req_idx];
  assign busy  = (state_q != StIdle);

  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_strobe = strobe_q;
  assign mem.mem_rnotw  = 1'b1;
  assign miss_count     = miss_q;

  // A store updates a resident line only; flush suppresses it.
  assign snoop_hit     = snoop_we & valid_q[snoop_idx] & (tag_q[snoop_idx] == snoop_tag);
  // A store to the very word being filled overrides the (stale) slowmem data.
  assign snoop_to_fill = snoop_we & (snoop_addr == fill_addr_q);
  assign snoop_upd     = snoop_hit & ~flush & ~(install & (snoop_idx == fill_idx));

  // Next-state logic: fill FSM, drop flag, miss counter and valid bits.
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    mem_addr_d  = mem_addr_q;
    strobe_d    = 1'b0;
    drop_d      = drop_q;
    miss_d      = miss_q;
    install     = 1'b0;

    // Flush during a fill: let it finish on mfc but discard the data.
    if (flush && state_q != StIdle) begin
      drop_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid && !hit && !flush) begin
          fill_addr_d = req_addr;
          mem_addr_d  = req_addr;
          strobe_d    = 1'b1;
          if (miss_q != {CNT_W{1'b1}}) begin
            miss_d = miss_q + CNT_W'(1);
          end
          state_d = StReq;
        end
      end
      StReq: begin
        state_d = StWait;
      end
      StWait: begin
        if (mem.mem_mfc) begin
          install = ~drop_q & ~flush;
          drop_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (install) begin
      valid_d[fill_idx] = 1'b1;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      fill_addr_q <= '0;
      mem_addr_q  <= '0;
      strobe_q    <= 1'b0;
      drop_q      <= 1'b0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      fill_addr_q <= fill_addr_d;
      mem_addr_q  <= mem_addr_d;
      strobe_q    <= strobe_d;
      drop_q      <= drop_d;
      miss_q      <= miss_d;
    end
  end

  // Tag/data arrays: fill install and snoop update; contents are qualified by valid.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= snoop_to_fill ? snoop_data : mem.mem_rdata;
    end
    if (snoop_upd) begin
      data_q[snoop_idx] <= snoop_data;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, conflict, snoop, flush mid-fill,
// flush with mfc, reset mid-fill.
module tb_icache_dm;

  localparam int MEMDELAY = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] instr;
  logic        hit;
  logic        busy;
  logic        flush = 1'b0;
  logic        snoop_we = 1'b0;
  logic [15:0] snoop_addr = '0;
  logic [15:0] snoop_data = '0;
  logic [15:0] miss_count;

  logic [15:0] m [256];
  int          n_cmp = 0;
  int          n_err = 0;
  int          strobe_cnt = 0;
  int          strobe_snap;

  icache_dm_if #(.ADDR_W(16), .DATA_W(16)) mem_bus ();

  icache_dm #(
    .ADDR_W (16),
    .DATA_W (16),
    .INDEX_W(3),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .instr     (instr),
    .hit       (hit),
    .busy      (busy),
    .flush     (flush),
    .snoop_we  (snoop_we),
    .snoop_addr(snoop_addr),
    .snoop_data(snoop_data),
    .mem       (mem_bus.master),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Count strobes seen by slowmem on active edges.
  always @(posedge clk) begin
    if (mem_bus.mem_strobe) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a missing address and follow it into WAIT.
  task automatic start_miss(input logic [15:0] a);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    #1 check("miss_hit", {31'd0, hit}, 32'd0);
    @(negedge clk);
    check("strobe_on", {31'd0, mem_bus.mem_strobe}, 32'd1);
    check("mem_addr", {16'd0, mem_bus.mem_addr}, {16'd0, a});
    check("busy_fill", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("strobe_off", {31'd0, mem_bus.mem_strobe}, 32'd0);
  endtask

  // Complete a fill after MEMDELAY and expect the requested word to hit.
  task automatic fetch_miss(input logic [15:0] a, input logic [15:0] exp);
    start_miss(a);
    repeat (MEMDELAY - 1) @(negedge clk);
    mem_bus.mem_mfc   = 1'b1;
    mem_bus.mem_rdata = m[a[7:0]];
    @(negedge clk);
    mem_bus.mem_mfc = 1'b0;
    #1;
    check("fill_hit", {31'd0, hit}, 32'd1);
    check("fill_instr", {16'd0, instr}, {16'd0, exp});
    check("fill_busy", {31'd0, busy}, 32'd0);
  endtask

  // Look up an address without letting a miss start a fill.
  task automatic probe(input string tag, input logic [15:0] a, input logic exp_hit);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    #1 check(tag, {31'd0, hit}, {31'd0, exp_hit});
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m[i] = 16'(i * 3);
    m[8'h05] = 16'hA123;
    m[8'h0D] = 16'h1111;
    m[8'h07] = 16'h7777;
    m[8'h03] = 16'h3333;
    mem_bus.mem_mfc   = 1'b0;
    mem_bus.mem_rdata = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hit", {31'd0, hit}, 32'd0);
    check("rst_strobe", {31'd0, mem_bus.mem_strobe}, 32'd0);
    check("rst_addr", {16'd0, mem_bus.mem_addr}, 32'd0);
    check("rst_cnt", {16'd0, miss_count}, 32'd0);
    check("rst_rnotw", {31'd0, mem_bus.mem_rnotw}, 32'd1);
    reset = 1'b0;

    // Cold miss
    fetch_miss(16'h0005, 16'hA123);
    check("cold_cnt", {16'd0, miss_count}, 32'd1);

    // Conflict on index 5
    fetch_miss(16'h000D, 16'h1111);
    fetch_miss(16'h0005, 16'hA123);
    check("conflict_cnt", {16'd0, miss_count}, 32'd3);

    // Snoop hit updates data without a fill
    @(negedge clk);
    req_valid  = 1'b0;
    snoop_we   = 1'b1;
    snoop_addr = 16'h0005;
    snoop_data = 16'hBEEF;
    @(negedge clk);
    snoop_we    = 1'b0;
    strobe_snap = strobe_cnt;
    req_valid   = 1'b1;
    req_addr    = 16'h0005;
    #1;
    check("snoop_hit", {31'd0, hit}, 32'd1);
    check("snoop_instr", {16'd0, instr}, 32'h0000BEEF);
    @(negedge clk);
    check("snoop_nostrobe", strobe_cnt, strobe_snap);
    // Same index, different tag: no effect
    snoop_we   = 1'b1;
    snoop_addr = 16'h0015;
    snoop_data = 16'hDEAD;
    @(negedge clk);
    snoop_we = 1'b0;
    #1;
    check("snoop_miss_instr", {16'd0, instr}, 32'h0000BEEF);
    check("snoop_cnt", {16'd0, miss_count}, 32'd3);

    // Flush during WAIT: fill consumed, nothing installed
    start_miss(16'h0007);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd1);
    mem_bus.mem_mfc   = 1'b1;
    mem_bus.mem_rdata = m[8'h07];
    @(negedge clk);
    mem_bus.mem_mfc = 1'b0;
    #1;
    check("flush_done", {31'd0, busy}, 32'd0);
    check("flush_miss7", {31'd0, hit}, 32'd0);
    req_valid = 1'b0;
    probe("flush_miss5", 16'h0005, 1'b0);
    check("flush_cnt", {16'd0, miss_count}, 32'd4);

    // Flush and mfc on the same edge
    start_miss(16'h0003);
    repeat (MEMDELAY - 1) @(negedge clk);
    mem_bus.mem_mfc   = 1'b1;
    mem_bus.mem_rdata = m[8'h03];
    flush = 1'b1;
    @(negedge clk);
    mem_bus.mem_mfc = 1'b0;
    flush = 1'b0;
    #1;
    check("fm_busy", {31'd0, busy}, 32'd0);
    check("fm_miss", {31'd0, hit}, 32'd0);
    req_valid = 1'b0;
    fetch_miss(16'h0003, 16'h3333);
    check("fm_cnt", {16'd0, miss_count}, 32'd6);

    // Reset mid-fill, then a stale mfc
    start_miss(16'h0007);
    reset = 1'b1;
    #1;
    check("rmid_busy", {31'd0, busy}, 32'd0);
    check("rmid_cnt", {16'd0, miss_count}, 32'd0);
    check("rmid_strobe", {31'd0, mem_bus.mem_strobe}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    mem_bus.mem_mfc   = 1'b1;
    mem_bus.mem_rdata = m[8'h07];
    @(negedge clk);
    mem_bus.mem_mfc = 1'b0;
    check("stale_busy", {31'd0, busy}, 32'd0);
    probe("stale_miss7", 16'h0007, 1'b0);
    probe("stale_miss3", 16'h0003, 1'b0);
    check("stale_cnt", {16'd0, miss_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
